// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    // Operation sequencing: accept operands, step digits, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_DIGIT = 4;
    localparam int NDIG      = DEF_SIZE / DEF_DIGIT;
    localparam int CNT_W     = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Digit-counter width for an arbitrary SIZE/DIGIT pair; never below 1 bit.
    function automatic int cnt_width(input int size, input int digit);
        int n;
        n = size / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple slice. The caller supplies the already
// inverted subtrahend digit, so this is a plain adder slice that also
// exposes the carry into its top bit for signed-overflow detection.
module sub_digit
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] nb_dig,
    input  logic             cin,
    output logic [DIGIT-1:0] s_dig,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // Ripple the carry across the digit, one full adder per bit.
    always_comb begin
        c     = '0;
        s_dig = '0;
        c[0]  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s_dig[i] = a_dig[i] ^ nb_dig[i] ^ c[i];
            c[i+1]   = (a_dig[i] & nb_dig[i]) | (c[i] & (a_dig[i] ^ nb_dig[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: d = a - b - bin, DIGIT bits per
// clock through one shared slice, with valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] d,
    output logic            borrowout,
    output logic            overflow,
    output logic            zero
);

    localparam int ND = SIZE / DIGIT;
    localparam int CW = cnt_width(SIZE, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] ash;
    logic [SIZE-1:0] bsh;
    logic [SIZE-1:0] dsh;
    logic            carry;

    logic [DIGIT-1:0] s_dig;
    logic             cout;
    logic             c_msb;
    logic [SIZE-1:0]  d_next;

    // Subtraction as a + ~b + ~bin: the slice sees the inverted subtrahend.
    sub_digit #(.DIGIT(DIGIT)) u_slice (
        .a_dig  (ash[DIGIT-1:0]),
        .nb_dig (~bsh[DIGIT-1:0]),
        .cin    (carry),
        .s_dig  (s_dig),
        .cout   (cout),
        .c_msb  (c_msb)
    );

    // Result digit enters at the top; after ND shifts the LSB digit lands at bit 0.
    always_comb begin
        d_next = (dsh >> DIGIT) | (SIZE'(s_dig) << (SIZE - DIGIT));
    end

    assign in_ready = (state == IDLE);
    assign d        = dsh;

    // Sequencer, operand/result shift registers and registered flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ash       <= '0;
            bsh       <= '0;
            dsh       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            borrowout <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ash   <= a;
                        bsh   <= b;
                        carry <= ~bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ash   <= ash >> DIGIT;
                    bsh   <= bsh >> DIGIT;
                    dsh   <= d_next;
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // cout is c[SIZE], c_msb is c[SIZE-1] on the final digit.
                        borrowout <= ~cout;
                        overflow  <= cout ^ c_msb;
                        zero      <= ~|d_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are pushed at the
// accepting edge and popped when out_valid appears.
module tb_serial_subtractor;

    localparam int SIZE = 32;
    localparam int NDIG = 8;

    typedef struct packed {
        logic [SIZE-1:0] d;
        logic            bo;
        logic            ov;
        logic            z;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] d;
    logic            borrowout;
    logic            overflow;
    logic            zero;

    int n_chk;
    int n_fail;
    exp_t sb[$];

    serial_subtractor #(.SIZE(SIZE), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrowout (borrowout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y, input logic bi);
        exp_t e;
        logic [SIZE:0] full;
        full = {1'b0, x} + {1'b0, ~y} + {{SIZE{1'b0}}, ~bi};
        e.d  = full[SIZE-1:0];
        e.bo = ~full[SIZE];
        e.ov = (x[SIZE-1] != y[SIZE-1]) && (e.d[SIZE-1] != x[SIZE-1]);
        e.z  = (e.d == '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, track latency, optionally stall the consumer and
    // scramble the operand inputs while the operation runs.
    task automatic run_op(input string tag, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                          input logic bi, input int hold, input bit scramble);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        out_ready = (hold == 0);
        for (int k = 0; k < 30 && !in_ready; k++) tick();
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a = x; b = y; bin = bi; in_valid = 1'b1;
        tick();
        sb.push_back(model(x, y, bi));
        in_valid = 1'b0;
        lat  = 0;
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (scramble) begin
                a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
            end
            tick();
            if (out_valid) begin
                seen = 1;
                lat  = k;
            end
        end
        if (!seen) begin
            chk({tag, " timeout"}, 64'(out_valid), 64'd1);
            void'(sb.pop_front());
            return;
        end
        if (tag == "basic") chk({tag, " latency"}, 64'(lat), 64'(NDIG));
        e = sb.pop_front();
        got = '{d: d, bo: borrowout, ov: overflow, z: zero};
        chk({tag, " d"}, 64'(d), 64'(e.d));
        chk({tag, " flags"}, 64'({borrowout, overflow, zero}), 64'({e.bo, e.ov, e.z}));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, " hold"}, 64'({out_valid, in_ready, d, borrowout, overflow, zero}),
                64'({1'b1, 1'b0, got.d, got.bo, got.ov, got.z}));
        end
        out_ready = 1'b1;
        tick();
        chk({tag, " release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        chk("reset", 64'({in_ready, out_valid, d, borrowout, overflow, zero}), 64'({1'b1, 1'b0, 32'd0, 3'b000}));
        rst_n = 1'b1;
        tick();

        run_op("basic", 32'd5, 32'd3, 1'b0, 0, 0);
        run_op("neg",   32'd3, 32'd5, 1'b0, 0, 0);
        run_op("ovpos", 32'h8000_0000, 32'd1, 1'b0, 0, 0);
        run_op("ovneg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op("bin",   32'd0, 32'd0, 1'b1, 0, 0);
        run_op("zero",  32'd7, 32'd7, 1'b0, 0, 0);
        run_op("stall", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5, 1);

        // Abort in the middle of an operation.
        out_ready = 1'b1;
        a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort", 64'({in_ready, out_valid, d}), 64'({1'b1, 1'b0, 32'd0}));
        for (int k = 0; k < NDIG + 2; k++) begin
            tick();
            chk("abort quiet", 64'(out_valid), 64'd0);
        end
        run_op("after", 32'd9, 32'd4, 1'b0, 0, 0);

        for (int i = 0; i < 6; i++)
            run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), i % 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, digit-serial two's-complement subtractor computing d = a - b - bin.
- Processes DIGIT bits per clock through one shared digit slice, trading latency for area.
- Complements the existing combinational ripple adder, and returns the same borrow and overflow flag set.
- Sits behind a valid/ready handshake on both sides so the ALU datapath can stall it.

Parameters:
- SIZE, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; NDIG = SIZE/DIGIT cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  SIZE  minuend.
- b  in  SIZE  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- d  out  SIZE  difference.
- borrowout  out  1  1 when unsigned a < b + bin.
- overflow  out  1  signed overflow.
- zero  out  1  d == 0.

Behaviour:
- Arithmetic: d = a + ~b + ~bin, with carry chain c[0] = ~bin.
  - borrowout = ~c[SIZE].
  - overflow = c[SIZE] ^ c[SIZE-1].
  - zero = ~|d.
  - All arithmetic is modulo 2^SIZE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch a, b and carry = ~bin, clear digit counter, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the slice consumes the low DIGIT bits of the a/b shift registers plus the carry register.
  - Its DIGIT-bit result shifts into the top of the d register, which shifts right by DIGIT.
  - The carry register updates with the slice carry-out.
  - On the last digit (counter == NDIG-1), also capture the carry into the slice MSB as c[SIZE-1] for overflow, then go to DONE.
- DONE:
  - out_valid = 1; d, borrowout, overflow and zero are stable.
  - Leave for IDLE on out_ready.
  - No new operand is accepted in the same cycle as the release; in_ready rises the following cycle.
- Latency: out_valid asserts NDIG cycles after the accepting edge (8 for the defaults). Throughput is one operation per NDIG+2 cycles with out_ready held high.
- Back-pressure: while out_valid=1 and out_ready=0, all outputs hold indefinitely.
- Inputs a, b and bin are ignored except at the accepting edge, so changes during RUN have no effect.
- Reset: takes effect on any clock edge with rst_n=0, in any state.
  - Returns to IDLE, aborts any operation in flight, and produces no out_valid.
  - in_ready=1; out_valid=0; d=0; borrowout=0; overflow=0; zero=0.
- Outputs come straight from registers; no combinational path exists from inputs to outputs except in_ready, which is derived from state only.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/RUN/DONE);
  - localparam NDIG = SIZE/DIGIT;
  - counter width $clog2(NDIG).
- One sub-module, sub_digit: a combinational DIGIT-bit ripple slice.
  - Inputs: a_dig, ~b_dig, cin.
  - Outputs: s_dig, cout, and c_msb (carry into the top bit, used for overflow).
- Top level holds the FSM, counter, shift registers and flag registers.

Test Plan:
- a=5, b=3, bin=0 -> d=0x00000002, borrowout=0, overflow=0, zero=0; out_valid exactly 8 cycles after accept.
- a=3, b=5, bin=0 -> d=0xFFFFFFFE, borrowout=1, overflow=0.
- a=0x80000000, b=1, bin=0 -> d=0x7FFFFFFF, borrowout=0, overflow=1.
- a=0x7FFFFFFF, b=0xFFFFFFFF, bin=0 -> d=0x80000000, borrowout=1, overflow=1.
- a=0, b=0, bin=1 -> d=0xFFFFFFFF, borrowout=1.
- a=7, b=7, bin=0 -> d=0, zero=1.
- Hold out_ready=0 for 5 cycles after out_valid, and change a/b during RUN -> outputs unchanged and in_ready=0 throughout; releasing out_ready returns the FSM to IDLE, with in_ready=1 on the next cycle.
- Pulse rst_n=0 for one cycle at RUN cycle 4 -> next cycle in IDLE, out_valid=0, d=0; a subsequent operation 9-4 gives d=5.
